video_fetch_ctrl: RTL and testbench

//  Framebuffer fetch scheduler for the 640x480 bitplane video output.
//  - Reads packed pixel words from memory over a strobe/ack read port into a show-ahead word FIFO.
//  - Presents red/green/blue/bright bytes to the display core; the display pops one entry per fetch_next.
//  - Restarts each frame on vsync and rewinds one line on line_repeat, for Y doubling.

---
 rtl/video_fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_video_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_ctrl.sv
// rtl/video_fetch_ctrl.sv - framebuffer fetch scheduler feeding a show-ahead pixel word FIFO
module video_fetch_ctrl #(
  parameter int C_addr_bits   = 30,
  parameter int C_fifo_bits   = 4,
  parameter int C_burst       = 4,
  parameter int C_line_words  = 80,
  parameter int C_frame_words = 38400
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [C_addr_bits-1:0] base_addr,
  input  logic                   vsync,
  input  logic                   line_repeat,
  input  logic                   fetch_next,
  output logic [7:0]             red_byte,
  output logic [7:0]             green_byte,
  output logic [7:0]             blue_byte,
  output logic [7:0]             bright_byte,
  output logic [C_addr_bits-1:0] mem_addr,
  output logic                   mem_strobe,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_data,
  output logic                   underflow
);

  localparam int DEPTH = 1 << C_fifo_bits;
  localparam int FW    = $clog2(C_frame_words + 1);
  localparam int LW    = $clog2(C_line_words);
  localparam int BW    = $clog2(C_burst + 1);
  localparam logic [C_addr_bits-1:0] ADDR_ONE = 1;
  localparam logic [C_fifo_bits:0]   DEPTH_W  = (C_fifo_bits+1)'(DEPTH);
  localparam logic [C_fifo_bits:0]   BURST_W  = (C_fifo_bits+1)'(C_burst);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                 state;
  logic [31:0]            fifo_mem [DEPTH];
  logic [C_fifo_bits-1:0] wr_ptr, rd_ptr;
  logic [C_fifo_bits:0]   count;
  logic [C_addr_bits-1:0] fetch_addr, line_start;
  logic [FW-1:0]          frame_cnt;
  logic [LW-1:0]          line_cnt;
  logic [BW-1:0]          burst_cnt;
  logic                   flush;
  logic                   vsync_q, vsync_q2, lrep_q, lrep_q2;

  logic                   frame_evt, rewind_evt, flush_now;
  logic                   accept, push, pop, fifo_empty;
  logic [C_fifo_bits:0]   free_slots;
  logic [C_addr_bits-1:0] next_addr;
  logic [31:0]            head;

  // vsync outranks line_repeat when both edges land together
  assign frame_evt  = vsync_q & ~vsync_q2;
  assign rewind_evt = lrep_q & ~lrep_q2 & ~frame_evt;
  assign flush_now  = frame_evt | rewind_evt;

  assign fifo_empty = (count == '0);
  assign free_slots = DEPTH_W - count;
  assign next_addr  = fetch_addr + ADDR_ONE;

  // An ack that races a flush, or arrives while one is pending, is dropped
  assign accept = (state == S_REQ) & mem_ack & ~flush & ~flush_now;
  assign push   = accept;
  assign pop    = fetch_next & ~fifo_empty & ~flush_now;

  assign head        = fifo_mem[rd_ptr];
  assign red_byte    = fifo_empty ? 8'd0 : head[7:0];
  assign green_byte  = fifo_empty ? 8'd0 : head[15:8];
  assign blue_byte   = fifo_empty ? 8'd0 : head[23:16];
  assign bright_byte = fifo_empty ? 8'd0 : head[31:24];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      mem_strobe <= 1'b0;
      mem_addr   <= '0;
      fetch_addr <= base_addr;
      line_start <= base_addr;
      frame_cnt  <= '0;
      line_cnt   <= '0;
      burst_cnt  <= '0;
      flush      <= 1'b0;
      underflow  <= 1'b0;
      vsync_q    <= 1'b0;
      vsync_q2   <= 1'b0;
      lrep_q     <= 1'b0;
      lrep_q2    <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      vsync_q2 <= vsync_q;
      lrep_q   <= line_repeat;
      lrep_q2  <= lrep_q;

      if (fetch_next && fifo_empty && !flush_now) underflow <= 1'b1;

      if (frame_evt) begin
        fetch_addr <= base_addr;
        line_start <= base_addr;
        frame_cnt  <= '0;
        line_cnt   <= '0;
      end else if (rewind_evt) begin
        fetch_addr <= line_start;
        frame_cnt  <= frame_cnt - FW'(line_cnt);
        line_cnt   <= '0;
      end else if (accept) begin
        fetch_addr <= next_addr;
        frame_cnt  <= frame_cnt + 1'b1;
        if (line_cnt == LW'(C_line_words - 1)) begin
          line_cnt   <= '0;
          line_start <= next_addr;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          // Hold off one cycle on a flush so the request uses the rewound address
          if (flush_now) begin
            state <= S_IDLE;
          end else if (frame_cnt == FW'(C_frame_words)) begin
            state <= S_DONE;
          end else if (enable && free_slots >= BURST_W) begin
            state      <= S_REQ;
            mem_strobe <= 1'b1;
            mem_addr   <= fetch_addr;
            burst_cnt  <= '0;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (flush || flush_now) begin
              state      <= S_IDLE;
              mem_strobe <= 1'b0;
              flush      <= 1'b0;
            end else if (burst_cnt == BW'(C_burst - 1) || !enable ||
                         frame_cnt == FW'(C_frame_words - 1)) begin
              state      <= S_IDLE;
              mem_strobe <= 1'b0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
              mem_addr  <= next_addr;
            end
          end else if (flush_now) begin
            flush <= 1'b1;
          end
        end
        S_DONE: begin
          mem_strobe <= 1'b0;
          if (frame_evt) state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          mem_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_fetch_ctrl.sv
// tb/tb_video_fetch_ctrl.sv - directed bench for video_fetch_ctrl
module tb_video_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [29:0] base_addr;
  logic        vsync;
  logic        line_repeat;
  logic        fetch_next;
  logic [7:0]  red_byte, green_byte, blue_byte, bright_byte;
  logic [29:0] mem_addr;
  logic        mem_strobe;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        underflow;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_count = 0;
  int ack_limit = 1 << 30;
  int ack_lat   = 0;
  int wait_cnt  = 0;
  bit auto_pop  = 1'b0;
  logic [29:0] addr_log [$];

  video_fetch_ctrl dut (
    .clk(clk), .resetn(resetn), .enable(enable), .base_addr(base_addr),
    .vsync(vsync), .line_repeat(line_repeat), .fetch_next(fetch_next),
    .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
    .bright_byte(bright_byte), .mem_addr(mem_addr), .mem_strobe(mem_strobe),
    .mem_ack(mem_ack), .mem_data(mem_data), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {~lo, a[15:8], lo + 8'h11, lo};
  endfunction

  function automatic logic [31:0] bytes_out();
    return {bright_byte, blue_byte, green_byte, red_byte};
  endfunction

  // Memory responder and optional display drain, acting on the falling edge
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (resetn && mem_strobe && ack_count < ack_limit) begin
      if (wait_cnt >= ack_lat) begin
        mem_ack  = 1'b1;
        mem_data = word_of(mem_addr);
        addr_log.push_back(mem_addr);
        ack_count++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (auto_pop) fetch_next = (bytes_out() != 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    fetch_next = 1'b1;
    tick(1);
    fetch_next = 1'b0;
  endtask

  task automatic do_reset(input logic [29:0] base);
    base_addr   = base;
    resetn      = 1'b0;
    enable      = 1'b0;
    vsync       = 1'b0;
    line_repeat = 1'b0;
    fetch_next  = 1'b0;
    auto_pop    = 1'b0;
    ack_limit   = 1 << 30;
    tick(2);
    resetn = 1'b1;
    addr_log.delete();
    ack_count = 0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (ack_count < n && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (ack_count < n) $display("FAIL %s timeout: acks %0d required %0d", name, ack_count, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset(30'h100);
    n_checks++; if (mem_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", mem_strobe); else n_pass++;
    n_checks++; if (mem_addr !== 30'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b want 0", underflow); else n_pass++;
    n_checks++; if (bytes_out() !== 32'h0) $display("FAIL reset_bytes: got %h want 0", bytes_out()); else n_pass++;
  endtask

  task automatic test_first_burst();
    ack_lat = 1;
    enable  = 1'b1;
    wait_acks(4, 50, "first_burst");
    enable = 1'b0;
    tick(5);
    n_checks++; if (ack_count !== 4) $display("FAIL first_burst_count: got %0d want 4", ack_count); else n_pass++;
    n_checks++; if (mem_strobe !== 1'b0) $display("FAIL first_burst_idle: got %b want 0", mem_strobe); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (addr_log[i] !== 30'h100 + 30'(i)) $display("FAIL first_burst_addr%0d: got %h want %h", i, addr_log[i], 30'h100 + 30'(i));
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bytes_out() !== word_of(30'h100 + 30'(i))) $display("FAIL first_burst_head%0d: got %h want %h", i, bytes_out(), word_of(30'h100 + 30'(i)));
      else n_pass++;
      pop_one();
    end
    n_checks++; if (bytes_out() !== 32'h0) $display("FAIL first_burst_empty: got %h want 0", bytes_out()); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL first_burst_underflow: got %b want 0", underflow); else n_pass++;
  endtask

  task automatic test_fifo_full();
    addr_log.delete();
    ack_count = 0;
    ack_lat   = 0;
    enable    = 1'b1;
    tick(60);
    n_checks++; if (ack_count !== 16) $display("FAIL full_count: got %0d want 16", ack_count); else n_pass++;
    n_checks++; if (mem_strobe !== 1'b0) $display("FAIL full_strobe: got %b want 0", mem_strobe); else n_pass++;
    n_checks++; if (bytes_out() !== word_of(30'h104)) $display("FAIL full_head: got %h want %h", bytes_out(), word_of(30'h104)); else n_pass++;
    pop_one();
    tick(20);
    n_checks++; if (ack_count !== 16) $display("FAIL full_one_free: got %0d want 16", ack_count); else n_pass++;
    repeat (3) pop_one();
    n_checks++; if (bytes_out() !== word_of(30'h108)) $display("FAIL full_head4: got %h want %h", bytes_out(), word_of(30'h108)); else n_pass++;
    tick(20);
    n_checks++; if (ack_count !== 20) $display("FAIL full_refill: got %0d want 20", ack_count); else n_pass++;
    n_checks++; if (addr_log[16] !== 30'h114) $display("FAIL full_refill_addr: got %h want 114", addr_log[16]); else n_pass++;
    enable = 1'b0;
    tick(2);
    repeat (16) pop_one();
    n_checks++; if (bytes_out() !== 32'h0) $display("FAIL full_drained: got %h want 0", bytes_out()); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL full_underflow: got %b want 0", underflow); else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset(30'h200);
    ack_lat = 0;
    pop_one();
    n_checks++; if (underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", underflow); else n_pass++;
    n_checks++; if (bytes_out() !== 32'h0) $display("FAIL uf_bytes: got %h want 0", bytes_out()); else n_pass++;
    enable = 1'b1;
    wait_acks(4, 50, "uf_fill");
    enable = 1'b0;
    tick(3);
    n_checks++; if (bytes_out() !== word_of(30'h200)) $display("FAIL uf_head: got %h want %h", bytes_out(), word_of(30'h200)); else n_pass++;
    n_checks++; if (underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", underflow); else n_pass++;
    do_reset(30'h200);
    n_checks++; if (underflow !== 1'b0) $display("FAIL uf_clear: got %b want 0", underflow); else n_pass++;
  endtask

  task automatic test_full_frame();
    int k;
    do_reset(30'h1000);
    ack_lat  = 0;
    auto_pop = 1'b1;
    enable   = 1'b1;
    k = 0;
    while (!(ack_count == 38400 && !mem_strobe) && k < 60000) begin
      tick(1);
      k++;
    end
    tick(10);
    n_checks++; if (ack_count !== 38400) $display("FAIL frame_acks: got %0d want 38400", ack_count); else n_pass++;
    n_checks++; if (mem_strobe !== 1'b0) $display("FAIL frame_done_strobe: got %b want 0", mem_strobe); else n_pass++;
    n_checks++; if (addr_log[addr_log.size()-1] !== 30'h1000 + 30'd38399) $display("FAIL frame_last_addr: got %h want %h", addr_log[addr_log.size()-1], 30'h1000 + 30'd38399); else n_pass++;
    auto_pop   = 1'b0;
    fetch_next = 1'b0;
    base_addr  = 30'h3000;
    vsync      = 1'b1;
    tick(3);
    n_checks++; if (bytes_out() !== 32'h0) $display("FAIL frame_vsync_empty: got %h want 0", bytes_out()); else n_pass++;
    k = 0;
    while (!mem_strobe && k < 20) begin
      tick(1);
      k++;
    end
    n_checks++; if (mem_strobe !== 1'b1 || mem_addr !== 30'h3000) $display("FAIL frame_restart_addr: got %b/%h want 1/3000", mem_strobe, mem_addr); else n_pass++;
    vsync  = 1'b0;
    enable = 1'b0;
    tick(10);
  endtask

  task automatic test_line_repeat();
    do_reset(30'h400);
    ack_lat   = 0;
    ack_limit = 85;
    auto_pop  = 1'b1;
    enable    = 1'b1;
    wait_acks(80, 400, "rep_fill80");
    auto_pop   = 1'b0;
    fetch_next = 1'b0;
    wait_acks(85, 50, "rep_fill85");
    tick(3);
    n_checks++; if (mem_strobe !== 1'b1 || mem_addr !== 30'h455) $display("FAIL rep_pending: got %b/%h want 1/455", mem_strobe, mem_addr); else n_pass++;
    n_checks++; if (bytes_out() === 32'h0) $display("FAIL rep_prefill: got %h want nonzero", bytes_out()); else n_pass++;
    line_repeat = 1'b1;
    tick(4);
    n_checks++; if (bytes_out() !== 32'h0) $display("FAIL rep_flushed: got %h want 0", bytes_out()); else n_pass++;
    n_checks++; if (mem_strobe !== 1'b1) $display("FAIL rep_strobe_held: got %b want 1", mem_strobe); else n_pass++;
    ack_limit = 1 << 30;
    wait_acks(90, 50, "rep_refetch");
    enable = 1'b0;
    tick(3);
    n_checks++; if (addr_log[86] !== 30'h450) $display("FAIL rep_rewind_addr: got %h want 450", addr_log[86]); else n_pass++;
    n_checks++; if (bytes_out() !== word_of(30'h450)) $display("FAIL rep_head: got %h want %h", bytes_out(), word_of(30'h450)); else n_pass++;
    line_repeat = 1'b0;
  endtask

  task automatic test_vsync_pending();
    do_reset(30'h500);
    ack_lat   = 0;
    ack_limit = 6;
    enable    = 1'b1;
    wait_acks(6, 50, "vs_fill");
    tick(3);
    n_checks++; if (mem_strobe !== 1'b1 || mem_addr !== 30'h506) $display("FAIL vs_pending: got %b/%h want 1/506", mem_strobe, mem_addr); else n_pass++;
    base_addr = 30'h700;
    vsync     = 1'b1;
    tick(3);
    ack_limit = 7;
    tick(3);
    n_checks++; if (ack_count !== 7) $display("FAIL vs_late_ack: got %0d want 7", ack_count); else n_pass++;
    n_checks++; if (bytes_out() !== 32'h0) $display("FAIL vs_discard: got %h want 0", bytes_out()); else n_pass++;
    n_checks++; if (mem_strobe !== 1'b1 || mem_addr !== 30'h700) $display("FAIL vs_restart_addr: got %b/%h want 1/700", mem_strobe, mem_addr); else n_pass++;
    ack_limit = 1 << 30;
    wait_acks(11, 50, "vs_refetch");
    enable = 1'b0;
    tick(3);
    n_checks++; if (bytes_out() !== word_of(30'h700)) $display("FAIL vs_head: got %h want %h", bytes_out(), word_of(30'h700)); else n_pass++;
    vsync = 1'b0;
  endtask

  initial begin
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    test_reset();
    test_first_burst();
    test_fifo_full();
    test_underflow();
    test_line_repeat();
    test_vsync_pending();
    test_full_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
